// File: rtl/fp_min_arb_if.sv
// Requester/result bundle for the shared minNum arbiter.
interface fp_min_arb_if #(
  parameter int N_REQ = 4,
  parameter int FP_W  = 32,
  parameter int ID_W  = 2
);
  logic [N_REQ-1:0]      req_valid;
  logic [N_REQ-1:0]      req_ready;
  logic [N_REQ*FP_W-1:0] req_a;
  logic [N_REQ*FP_W-1:0] req_b;
  logic                  res_valid;
  logic                  res_ready;
  logic [FP_W-1:0]       res_data;
  logic [ID_W-1:0]       res_id;
  logic                  res_invalid;
  logic                  flag_invalid;
  logic                  flag_clr;

  modport master (
    output req_valid, req_a, req_b, res_ready, flag_clr,
    input  req_ready, res_valid, res_data, res_id, res_invalid, flag_invalid
  );

  modport slave (
    input  req_valid, req_a, req_b, res_ready, flag_clr,
    output req_ready, res_valid, res_data, res_id, res_invalid, flag_invalid
  );
endinterface

// File: rtl/fp_min_arb.sv
// Round-robin arbiter sharing one IEEE 754-2008 minNum datapath among N_REQ
// requesters, with a registered result and a sticky invalid-operation flag.
module fp_min_arb #(
  parameter int EXPO_W = 8,
  parameter int MANT_W = 23,
  parameter int N_REQ  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  fp_min_arb_if.slave bus
);
  localparam int FP_W = 1 + EXPO_W + MANT_W;
  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  gnt_idx;
  logic             gnt_any;
  logic [N_REQ-1:0] gnt;
  logic             can_load;
  logic             xfer;
  logic [FP_W-1:0]  a_sel, b_sel;
  logic [FP_W:0]    min_res;

  logic             res_valid_q;
  logic [FP_W-1:0]  res_data_q;
  logic [ID_W-1:0]  res_id_q;
  logic             res_invalid_q;
  logic             flag_q;

  function automatic int unsigned rr_idx(input logic [ID_W-1:0] p, input int unsigned k);
    return (32'(p) + k) % 32'(N_REQ);
  endfunction

  // Returns {invalid, result}.
  function automatic logic [FP_W:0] fp_min(input logic [FP_W-1:0] a, input logic [FP_W-1:0] b);
    logic a_nan, b_nan, a_snan, b_snan;
    logic [FP_W-1:0] qnan;
    a_nan  = (&a[FP_W-2 -: EXPO_W]) && (|a[MANT_W-1:0]);
    b_nan  = (&b[FP_W-2 -: EXPO_W]) && (|b[MANT_W-1:0]);
    a_snan = a_nan && !a[MANT_W-1];
    b_snan = b_nan && !b[MANT_W-1];
    qnan   = {1'b0, {EXPO_W{1'b1}}, 1'b1, {(MANT_W-1){1'b0}}};
    if (a_snan || b_snan)         return {1'b1, qnan};
    else if (a_nan && b_nan)      return {1'b0, qnan};
    else if (a_nan)               return {1'b0, b};
    else if (b_nan)               return {1'b0, a};
    else if (a[FP_W-1] != b[FP_W-1])
      return {1'b0, a[FP_W-1] ? a : b};
    // Same sign: magnitude order flips for negatives; ties keep A.
    else if (!a[FP_W-1])
      return {1'b0, (b[FP_W-2:0] < a[FP_W-2:0]) ? b : a};
    else
      return {1'b0, (b[FP_W-2:0] > a[FP_W-2:0]) ? b : a};
  endfunction

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (!gnt_any && bus.req_valid[rr_idx(ptr, k)]) begin
        gnt_any                 = 1'b1;
        gnt_idx                 = ID_W'(rr_idx(ptr, k));
        gnt[rr_idx(ptr, k)]     = 1'b1;
      end
    end
  end

  assign can_load      = !res_valid_q || bus.res_ready;
  assign xfer          = gnt_any && can_load;
  assign bus.req_ready = gnt & {N_REQ{can_load}};

  assign a_sel   = bus.req_a[gnt_idx*FP_W +: FP_W];
  assign b_sel   = bus.req_b[gnt_idx*FP_W +: FP_W];
  assign min_res = fp_min(a_sel, b_sel);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr           <= '0;
      res_valid_q   <= 1'b0;
      res_data_q    <= '0;
      res_id_q      <= '0;
      res_invalid_q <= 1'b0;
      flag_q        <= 1'b0;
    end else begin
      if (xfer) begin
        res_valid_q   <= 1'b1;
        res_data_q    <= min_res[FP_W-1:0];
        res_id_q      <= gnt_idx;
        res_invalid_q <= min_res[FP_W];
        ptr           <= (gnt_idx == ID_W'(N_REQ-1)) ? '0 : gnt_idx + 1'b1;
      end else if (res_valid_q && bus.res_ready) begin
        res_valid_q <= 1'b0;
      end
      // Set takes priority over a same-cycle clear.
      if (xfer && min_res[FP_W])
        flag_q <= 1'b1;
      else if (bus.flag_clr)
        flag_q <= 1'b0;
    end
  end

  assign bus.res_valid    = res_valid_q;
  assign bus.res_data     = res_data_q;
  assign bus.res_id       = res_id_q;
  assign bus.res_invalid  = res_invalid_q;
  assign bus.flag_invalid = flag_q;
endmodule

// File: tb/tb_fp_min_arb.sv
// Directed bench for fp_min_arb with a queue of expected results.
module tb_fp_min_arb;
  logic clk = 1'b0;
  logic rst_n;

  fp_min_arb_if #(.N_REQ(4), .FP_W(32), .ID_W(2)) bus ();

  fp_min_arb #(.EXPO_W(8), .MANT_W(23), .N_REQ(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  id;
    logic        inv;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  logic m_rv        = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    bus.req_a[i*32 +: 32] = a;
    bus.req_b[i*32 +: 32] = b;
  endtask

  // One clock: check req_ready before the edge, then the registered result after it.
  task automatic cycle(input logic [3:0] exp_ready, input logic push,
                       input logic [31:0] ed, input logic [1:0] eid, input logic einv);
    exp_t e;
    @(negedge clk);
    check("req_ready", 64'(bus.req_ready), 64'(exp_ready));
    if (push) exp_q.push_back('{d: ed, id: eid, inv: einv});
    @(posedge clk);
    #1;
    if (push) m_rv = 1'b1;
    else if (bus.res_ready) m_rv = 1'b0;
    check("res_valid", 64'(bus.res_valid), 64'(m_rv));
    if (push) begin
      e = exp_q.pop_front();
      check("res_data", 64'(bus.res_data), 64'(e.d));
      check("res_id", 64'(bus.res_id), 64'(e.id));
      check("res_invalid", 64'(bus.res_invalid), 64'(e.inv));
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.res_ready = 1'b1;
    bus.flag_clr  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_res_valid", 64'(bus.res_valid), 64'd0);
    check("rst_res_data", 64'(bus.res_data), 64'd0);
    check("rst_res_id", 64'(bus.res_id), 64'd0);
    check("rst_res_invalid", 64'(bus.res_invalid), 64'd0);
    check("rst_flag", 64'(bus.flag_invalid), 64'd0);
    check("rst_req_ready", 64'(bus.req_ready), 64'd0);
    rst_n = 1'b1;

    // Basic transfer and special values, back-to-back from requester 0
    bus.req_valid = 4'b0001;
    set_op(0, 32'h3F800000, 32'h40000000); cycle(4'b0001, 1, 32'h3F800000, 0, 0);
    set_op(0, 32'h7FC00000, 32'hFF800000); cycle(4'b0001, 1, 32'hFF800000, 0, 0);
    set_op(0, 32'h80000000, 32'h00000000); cycle(4'b0001, 1, 32'h80000000, 0, 0);
    set_op(0, 32'h7FC00001, 32'h7FC00001); cycle(4'b0001, 1, 32'h7FC00000, 0, 0);
    set_op(0, 32'hC0000000, 32'hBF800000); cycle(4'b0001, 1, 32'hC0000000, 0, 0);
    set_op(0, 32'h40000000, 32'h3F800000); cycle(4'b0001, 1, 32'h3F800000, 0, 0);
    set_op(0, 32'h3F800000, 32'h7FC00000); cycle(4'b0001, 1, 32'h3F800000, 0, 0);
    set_op(0, 32'h00000000, 32'h80000000); cycle(4'b0001, 1, 32'h80000000, 0, 0);

    // sNaN handling and sticky flag
    set_op(0, 32'h7F800001, 32'h3F800000); cycle(4'b0001, 1, 32'h7FC00000, 0, 1);
    check("flag_set", 64'(bus.flag_invalid), 64'd1);
    bus.flag_clr = 1'b1;
    set_op(0, 32'h3F800000, 32'hFF800001); cycle(4'b0001, 1, 32'h7FC00000, 0, 1);
    check("flag_set_wins", 64'(bus.flag_invalid), 64'd1);
    bus.req_valid = '0;
    cycle(4'b0000, 0, '0, '0, 0);
    check("flag_cleared", 64'(bus.flag_invalid), 64'd0);
    bus.flag_clr = 1'b0;

    // Round-robin: bring ptr to 0 via requester 3, then all four valid
    for (int i = 0; i < 4; i++) set_op(i, 32'h3F800000 + 32'(i), 32'h40000000);
    bus.req_valid = 4'b1000;
    cycle(4'b1000, 1, 32'h3F800003, 3, 0);
    bus.req_valid = 4'b1111;
    for (int n = 0; n < 9; n++) begin
      cycle(4'(1 << (n % 4)), 1, 32'h3F800000 + 32'(n % 4), 2'(n % 4), 0);
    end
    bus.req_valid = 4'b0101;
    cycle(4'b0100, 1, 32'h3F800002, 2, 0);
    cycle(4'b0001, 1, 32'h3F800000, 0, 0);

    // Back-pressure: result held, no grants
    bus.req_valid = 4'b1010;
    bus.res_ready = 1'b0;
    for (int n = 0; n < 3; n++) begin
      cycle(4'b0000, 0, '0, '0, 0);
      check("hold_data", 64'(bus.res_data), 64'h3F800000);
      check("hold_id", 64'(bus.res_id), 64'd0);
    end
    bus.res_ready = 1'b1;
    cycle(4'b0010, 1, 32'h3F800001, 1, 0);
    cycle(4'b1000, 1, 32'h3F800003, 3, 0);

    // Reset mid-stream with a pending invalid result
    bus.req_valid = 4'b0100;
    set_op(2, 32'h7F800001, 32'h3F800000);
    cycle(4'b0100, 1, 32'h7FC00000, 2, 1);
    check("pre_rst_flag", 64'(bus.flag_invalid), 64'd1);
    bus.req_valid = '0;
    bus.res_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_res_valid", 64'(bus.res_valid), 64'd0);
    check("mid_rst_flag", 64'(bus.flag_invalid), 64'd0);
    check("mid_rst_res_data", 64'(bus.res_data), 64'd0);
    m_rv = 1'b0;
    @(posedge clk);
    #1;
    rst_n         = 1'b1;
    bus.res_ready = 1'b1;
    set_op(2, 32'h3F800002, 32'h40000000);
    bus.req_valid = 4'b1010;
    cycle(4'b0010, 1, 32'h3F800001, 1, 0);
    bus.req_valid = '0;
    cycle(4'b0000, 0, '0, '0, 0);

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
